display_mode_scheduler: RTL and testbench
=========================================

// Module: display_mode_scheduler
// PURPOSE
//   Owns the shared character LCD path between the watch, watch-set, (reserved) and stopwatch modes.
//   Debounces the dip_sw mode request and defers each mode switch to an LCD frame boundary, so the
//   screen never shows a mixed frame. Routes sw_in buttons only to the mode that owns the display.
//   Sits between the mode blocks and lcd_driver; replaces the top-level combinational dip_sw mux.
// PARAMETERS
//   DEB_CYCLES  50000  clk cycles a decoded dip_sw request must hold stable before it is accepted
//   FRAME_LEN   32     characters per LCD frame; index_char == FRAME_LEN-1 marks the last one
//   BLANK_CHAR  8'h20  character driven while blanking (MODE_BLANK_EN only)
// PORTS
//   clk          in   1  system clock
//   rst          in   1  synchronous reset, active-high
//   dip_sw       in   4  mode select switches, not synchronised
//   sw_in        in   4  push buttons, active-high, already synchronised
//   index_char   in   5  character position currently requested by lcd_driver
//   char_strobe  in   1  1-cycle pulse: lcd_driver consumed data_char at index_char
//   data_mode0   in   8  character from the watch mode
//   data_mode1   in   8  character from the watch-set mode
//   data_mode2   in   8  character from the reserved mode
//   data_mode3   in   8  character from the stopwatch mode
//   data_char    out  8  character to lcd_driver
//   sw_mode0..3  out  4  sw_in gated to each mode; only the active mode sees presses
//   active_mode  out  2  mode currently owning the display
//   mode_changed out  1  1-cycle pulse on the cycle active_mode takes its new value
// BEHAVIOUR
//   Decode of dip_sw (combinational): 0001->1, 0010->2, 0100->3, any other value->0.
//   Debounce:
//   - A 16-bit counter clears whenever the decode differs from its value on the previous cycle.
//   - When the decode has been stable for DEB_CYCLES cycles, it is copied into req_mode.
//   FSM states:
//   - RUN: if req_mode != active_mode, go to PENDING.
//   - PENDING:
//     - If req_mode == active_mode again, return to RUN with no switch.
//     - Otherwise, on the cycle with char_strobe && index_char == FRAME_LEN-1, register
//       active_mode <= req_mode (latest value) and pulse mode_changed.
//     - The next state is RUN, or BLANK when MODE_BLANK_EN is defined.
//   - BLANK: stay until the next char_strobe && index_char == FRAME_LEN-1, then go to RUN.
//     A request arriving during BLANK is handled from RUN on the following cycle.
//   data_char:
//   - Combinational mux of data_mode[active_mode]: zero latency relative to index_char.
//   - In BLANK it is BLANK_CHAR.
//   Button gating:
//   - sw_modeN = sw_in when N == active_mode and the state is RUN; otherwise 4'b0.
//   - Presses in PENDING or BLANK are dropped.
//   - The gate takes effect in the same cycle as the state and active_mode change.
//   Reset values:
//   - state = RUN, active_mode = 0, req_mode = 0, debounce counter = 0, mode_changed = 0.
//   - data_char therefore equals data_mode0 and sw_mode1..3 = 0.
//   - A reset in PENDING or BLANK abandons the switch.
//   Boundaries:
//   - Frame end and a req_mode change on the same cycle: the new req_mode value is used.
//   - index_char values >= FRAME_LEN never count as a boundary.
//   - char_strobe while in RUN has no effect.
// CONFIGURATION
//   MODE_BLANK_EN defined:
//     After each switch, one full frame of BLANK_CHAR is shown before the new mode's characters.
//     Buttons stay gated off for that frame.
//   MODE_BLANK_EN undefined:
//     No BLANK state is built. Switching goes from PENDING straight to RUN, and the new mode's
//     characters appear starting at index 0 of the next frame.
// TESTING
//   1. Reset, dip_sw=0000, then buttons -> active_mode=0, data_char=data_mode0, sw_mode0=sw_in,
//      sw_mode1..3=0.
//   2. dip_sw=0001 held DEB_CYCLES-1 cycles, then 0000 -> req_mode stays 0, no PENDING,
//      mode_changed never pulses.
//   3. dip_sw=0100 held, frame strobes running
//      -> active_mode=3 exactly one cycle after the index 31 strobe, mode_changed pulses once,
//         no mode-3 character appears before index 0.
//   4. dip_sw 0001->0000 during PENDING, before the frame end -> back to RUN, active_mode stays 0.
//   5. Button held during PENDING
//      -> all sw_mode=0 until the switch; sw_mode1 follows sw_in after RUN is re-entered.
//   6. MODE_BLANK_EN: switch to mode 2 -> 32 strobes see data_char=8'h20, then data_mode2;
//      rst asserted mid-BLANK -> RUN, mode 0 on the next cycle.

Source files
------------

// File: rtl/display_mode_scheduler.sv
// display_mode_scheduler
//   Owns the shared character LCD path between the watch (0), watch-set (1),
//   reserved (2) and stopwatch (3) modes. The dip_sw mode request is decoded,
//   debounced and applied only at an LCD frame boundary, so a frame is never
//   drawn from two modes. Push buttons reach only the mode owning the display.
//
//   Optional feature macro: MODE_BLANK_EN
//     defined   -> one full frame of BLANK_CHAR follows every mode switch,
//                  with buttons gated off for that frame.
//     undefined -> the new mode is shown from index 0 of the next frame.
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  synchronous reset, active-high
//   dip_sw       in   4  mode select switches (unsynchronised)
//   sw_in        in   4  push buttons, active-high, synchronised
//   index_char   in   5  character position requested by lcd_driver
//   char_strobe  in   1  lcd_driver consumed data_char at index_char
//   data_mode0-3 in   8  character from each mode
//   data_char    out  8  character to lcd_driver
//   sw_mode0-3   out  4  sw_in gated to each mode
//   active_mode  out  2  mode currently owning the display
//   mode_changed out  1  pulse on the cycle active_mode takes its new value
module display_mode_scheduler #(
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned FRAME_LEN  = 32,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dip_sw,
  input  logic [3:0] sw_in,
  input  logic [4:0] index_char,
  input  logic       char_strobe,
  input  logic [7:0] data_mode0,
  input  logic [7:0] data_mode1,
  input  logic [7:0] data_mode2,
  input  logic [7:0] data_mode3,
  output logic [7:0] data_char,
  output logic [3:0] sw_mode0,
  output logic [3:0] sw_mode1,
  output logic [3:0] sw_mode2,
  output logic [3:0] sw_mode3,
  output logic [1:0] active_mode,
  output logic       mode_changed
);

`ifdef MODE_BLANK_EN
  typedef enum logic [1:0] {RUN, PENDING, BLANK} state_t;
`else
  typedef enum logic {RUN, PENDING} state_t;
`endif

  state_t      state;
  logic [1:0]  dec;
  logic [1:0]  dec_q;
  logic [1:0]  req_mode;
  logic [1:0]  req_nxt;
  logic [15:0] deb_cnt;
  logic        deb_done;
  logic        frame_end;
  logic        run;

  always_comb begin
    case (dip_sw)
      4'b0001: dec = 2'd1;
      4'b0010: dec = 2'd2;
      4'b0100: dec = 2'd3;
      default: dec = 2'd0;
    endcase
  end

  // Counter saturates at DEB_CYCLES-1; while saturated the stable decode is
  // (re)copied into req_mode every cycle.
  assign deb_done = (dec == dec_q) && (deb_cnt == 16'(DEB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q    <= '0;
      deb_cnt  <= '0;
      req_mode <= '0;
    end else begin
      dec_q <= dec;
      if (dec != dec_q)
        deb_cnt <= '0;
      else if (!deb_done)
        deb_cnt <= deb_cnt + 16'd1;
      else
        req_mode <= dec;
    end
  end

  // The FSM looks at the value req_mode is about to take, so a request
  // accepted on the frame-end cycle is the one that gets applied.
  assign req_nxt   = deb_done ? dec : req_mode;
  assign frame_end = char_strobe && (32'(index_char) == FRAME_LEN - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      active_mode  <= '0;
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
      case (state)
        RUN:
          if (req_nxt != active_mode) state <= PENDING;
        PENDING:
          if (req_nxt == active_mode) begin
            state <= RUN;
          end else if (frame_end) begin
            active_mode  <= req_nxt;
            mode_changed <= 1'b1;
`ifdef MODE_BLANK_EN
            state        <= BLANK;
`else
            state        <= RUN;
`endif
          end
`ifdef MODE_BLANK_EN
        BLANK:
          if (frame_end) state <= RUN;
`endif
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    case (active_mode)
      2'd0:    data_char = data_mode0;
      2'd1:    data_char = data_mode1;
      2'd2:    data_char = data_mode2;
      default: data_char = data_mode3;
    endcase
`ifdef MODE_BLANK_EN
    if (state == BLANK) data_char = BLANK_CHAR;
`endif
  end

  assign run      = (state == RUN);
  assign sw_mode0 = (run && active_mode == 2'd0) ? sw_in : '0;
  assign sw_mode1 = (run && active_mode == 2'd1) ? sw_in : '0;
  assign sw_mode2 = (run && active_mode == 2'd2) ? sw_in : '0;
  assign sw_mode3 = (run && active_mode == 2'd3) ? sw_in : '0;

endmodule

// File: tb/tb_display_mode_scheduler.sv
// tb_display_mode_scheduler
//   Directed bench for display_mode_scheduler with a short debounce window.
//   Each mode's character is {mode, 1'b0, index_char}, so the expected
//   data_char follows directly from the expected owner and the index.
module tb_display_mode_scheduler;
  localparam int unsigned DEB = 8;
`ifdef MODE_BLANK_EN
  localparam bit BLANK_BUILD = 1'b1;
`else
  localparam bit BLANK_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dip_sw;
  logic [3:0] sw_in;
  logic [4:0] index_char;
  logic       char_strobe;
  logic [7:0] data_mode0, data_mode1, data_mode2, data_mode3;
  logic [7:0] data_char;
  logic [3:0] sw_mode0, sw_mode1, sw_mode2, sw_mode3;
  logic [1:0] active_mode;
  logic       mode_changed;
  logic [3:0] sw_all [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign data_mode0 = {3'b000, index_char};
  assign data_mode1 = {3'b010, index_char};
  assign data_mode2 = {3'b100, index_char};
  assign data_mode3 = {3'b110, index_char};
  assign sw_all[0] = sw_mode0;
  assign sw_all[1] = sw_mode1;
  assign sw_all[2] = sw_mode2;
  assign sw_all[3] = sw_mode3;

  display_mode_scheduler #(
    .DEB_CYCLES(DEB),
    .FRAME_LEN (32),
    .BLANK_CHAR(8'h20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dip_sw      (dip_sw),
    .sw_in       (sw_in),
    .index_char  (index_char),
    .char_strobe (char_strobe),
    .data_mode0  (data_mode0),
    .data_mode1  (data_mode1),
    .data_mode2  (data_mode2),
    .data_mode3  (data_mode3),
    .data_char   (data_char),
    .sw_mode0    (sw_mode0),
    .sw_mode1    (sw_mode1),
    .sw_mode2    (sw_mode2),
    .sw_mode3    (sw_mode3),
    .active_mode (active_mode),
    .mode_changed(mode_changed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sw(input logic [1:0] m, input logic gated);
    for (int n = 0; n < 4; n++)
      check($sformatf("sw_mode%0d", n), 32'(sw_all[n]),
            32'((!gated && n == int'(m)) ? sw_in : 4'b0000));
  endtask

  // One frame of back-to-back strobes, index 0..31.
  task automatic run_frame(input logic [1:0] m, input logic blank, input logic gated);
    logic [4:0] idx;
    for (int i = 0; i < 32; i++) begin
      idx         = 5'(i);
      index_char  = idx;
      char_strobe = 1'b1;
      #1;
      check("frame_char", 32'(data_char), 32'(blank ? 8'h20 : {m, 1'b0, idx}));
      check("frame_act", 32'(active_mode), 32'(m));
      check("frame_mchg", 32'(mode_changed), 32'd0);
      check_sw(m, gated);
      tick();
    end
    char_strobe = 1'b0;
    index_char  = 5'd0;
  endtask

  // Called just after the edge that completed a switch to m.
  task automatic expect_switch(input logic [1:0] m);
    char_strobe = 1'b0;
    index_char  = 5'd0;
    #1;
    check("sw_act", 32'(active_mode), 32'(m));
    check("sw_mchg_pulse", 32'(mode_changed), 32'd1);
    check("sw_char0", 32'(data_char), 32'(BLANK_BUILD ? 8'h20 : {m, 6'd0}));
    check_sw(m, BLANK_BUILD);
    tick();
    check("sw_mchg_clear", 32'(mode_changed), 32'd0);
`ifdef MODE_BLANK_EN
    run_frame(m, 1'b1, 1'b1);
    #1;
    check("post_blank_char", 32'(data_char), 32'({m, 6'd0}));
    check_sw(m, 1'b0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dip_sw = 4'b0000; sw_in = 4'b0000;
    index_char = 5'd0; char_strobe = 1'b0;
    tick(); tick();
    rst = 1'b0;
    index_char = 5'd5; sw_in = 4'b1010;
    #1;
    // reset state
    check("rst_act", 32'(active_mode), 32'd0);
    check("rst_mchg", 32'(mode_changed), 32'd0);
    check("rst_char", 32'(data_char), 32'h05);
    check_sw(2'd0, 1'b0);

    // request shorter than the debounce window is ignored
    sw_in  = 4'b0101;
    dip_sw = 4'b0001;
    for (int i = 0; i < int'(DEB) - 1; i++) begin
      tick();
      check("deb_short_sw0", 32'(sw_mode0), 32'(sw_in));
      check("deb_short_mchg", 32'(mode_changed), 32'd0);
    end
    dip_sw = 4'b0000;
    for (int i = 0; i < int'(DEB) + 4; i++) begin
      tick();
      check("deb_after_sw0", 32'(sw_mode0), 32'(sw_in));
      check("deb_after_act", 32'(active_mode), 32'd0);
    end

    // request withdrawn while pending: no switch
    dip_sw = 4'b0001;
    repeat (DEB + 2) tick();
    check("wd_pending_sw0", 32'(sw_mode0), 32'd0);
    check("wd_pending_act", 32'(active_mode), 32'd0);
    dip_sw = 4'b0000;
    repeat (DEB + 2) tick();
    check("wd_run_sw0", 32'(sw_mode0), 32'(sw_in));
    run_frame(2'd0, 1'b0, 1'b0);
    check("wd_act", 32'(active_mode), 32'd0);

    // switch to stopwatch at the frame end, buttons held throughout
    sw_in  = 4'b1111;
    dip_sw = 4'b0100;
    repeat (DEB + 2) tick();
    check("m3_pending_act", 32'(active_mode), 32'd0);
    run_frame(2'd0, 1'b0, 1'b1);
    expect_switch(2'd3);
    run_frame(2'd3, 1'b0, 1'b0);

    // button held across the switch to watch-set
    sw_in  = 4'b0110;
    dip_sw = 4'b0001;
    repeat (DEB + 2) tick();
    check_sw(2'd3, 1'b1);
    run_frame(2'd3, 1'b0, 1'b1);
    expect_switch(2'd1);
    check("m1_sw1", 32'(sw_mode1), 32'h6);

    // request changes on the frame-end cycle: the newer request wins
    dip_sw = 4'b0100;
    repeat (DEB + 2) tick();
    check("race_pending", 32'(sw_mode1), 32'd0);
    dip_sw = 4'b0010;
    repeat (DEB) tick();
    index_char  = 5'd31;
    char_strobe = 1'b1;
    tick();
    expect_switch(2'd2);

    // reset while pending abandons the switch
    dip_sw = 4'b0001;
    repeat (DEB + 2) tick();
    check("rstp_pending_sw2", 32'(sw_mode2), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dip_sw = 4'b0000;
    index_char = 5'd7;
    #1;
    check("rstp_act", 32'(active_mode), 32'd0);
    check("rstp_char", 32'(data_char), 32'h07);
    check_sw(2'd0, 1'b0);

`ifdef MODE_BLANK_EN
    // reset in the middle of a blank frame
    dip_sw = 4'b0010;
    repeat (DEB + 2) tick();
    run_frame(2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      index_char  = 5'(i);
      char_strobe = 1'b1;
      #1;
      check("rstb_blank_char", 32'(data_char), 32'h20);
      tick();
    end
    char_strobe = 1'b0;
    dip_sw      = 4'b0000;
    rst         = 1'b1;
    tick();
    rst        = 1'b0;
    index_char = 5'd3;
    #1;
    check("rstb_act", 32'(active_mode), 32'd0);
    check("rstb_char", 32'(data_char), 32'h03);
    check_sw(2'd0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
